// File: rtl/serial_subtractor_pkg.sv
// Shared FSM encoding and default operand width for the bit-serial subtractor.
package serial_subtractor_pkg;

  localparam int SUB_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: Diff = A - B - Bin, Bout set when a borrow is needed.
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic Diff,
  output logic Bout
);

  assign Diff = A ^ B ^ Bin;
  assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - Bin, LSB first, one full-subtractor cell plus a borrow flop.
// Operands enter on a start/ready handshake; the result is held on valid/ack.
//
// state | meaning
// IDLE  | ready=1, waiting for start; last result held on outputs
// RUN   | one operand bit per clock through the cell, WIDTH cycles
// DONE  | valid=1, result frozen until ack
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  input  logic             ack,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] DIFF,
  output logic             Bout,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr, d_sr, d_next;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             cell_d, cell_br;
  logic             accept, last_bit;

  full_subtractor u_cell (
    .A    (a_sr[0]),
    .B    (b_sr[0]),
    .Bin  (br),
    .Diff (cell_d),
    .Bout (cell_br)
  );

  assign d_next = {cell_d, d_sr[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    valid    = 1'b0;
    accept   = 1'b0;
    last_bit = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        last_bit = (cnt == LAST);
        if (last_bit) state_nx = DONE;
      end
      DONE: begin
        valid = 1'b1;
        if (ack) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Result registers only load on the final bit, so partial sums never reach DIFF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      d_sr     <= '0;
      br       <= 1'b0;
      cnt      <= '0;
      DIFF     <= '0;
      Bout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (accept) begin
      a_sr <= A;
      b_sr <= B;
      br   <= Bin;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      br   <= cell_br;
      d_sr <= d_next;
      if (last_bit) begin
        DIFF     <= d_next;
        Bout     <= cell_br;
        overflow <= br ^ cell_br;
        zero     <= (d_next == '0);
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
